// File: rtl/instruction_sequencer.sv
// instruction_sequencer: host-fed instruction FIFO with per-entry repeat
// counts. It drives the accelerator's instruction input one slot per cycle
// and fills idle or stalled cycles with NOP.
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous reset, active-high
//   hostIns      instruction word to enqueue
//   hostRpt      extra issues of hostIns (issued hostRpt+1 times)
//   hostValid    host push request
//   hostReady    FIFO not full (combinational)
//   run          enables fetching of new FIFO entries
//   stall        suppresses the issue slot this cycle
//   instruction  registered word to the accelerator
//   busy         FSM is in ISSUE
//   drained      one-cycle pulse on ISSUE->IDLE
//   count        FIFO occupancy, 0..2**FA
module instruction_sequencer #(
   parameter int unsigned depth    = 3,
   parameter int unsigned W        = 16,
   parameter int unsigned insW     = (2 > depth) ? 2 : depth,
   parameter int unsigned insD     = ((2 ** depth) > W) ? (2 ** depth) : W,
   parameter int unsigned insWidth = 4 + 2 + 2 * insW + insD,
   parameter int unsigned FA       = 4,
   parameter int unsigned RW       = 8,
   parameter logic [insWidth-1:0] NOP = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [insWidth-1:0] hostIns,
   input  logic [RW-1:0]       hostRpt,
   input  logic                hostValid,
   output logic                hostReady,
   input  logic                run,
   input  logic                stall,
   output logic [insWidth-1:0] instruction,
   output logic                busy,
   output logic                drained,
   output logic [FA:0]         count
);

   localparam int unsigned entW = RW + insWidth;
   localparam int unsigned cap  = 2 ** FA;
   localparam logic [FA:0] fullCount = (FA + 1)'(cap);

   typedef enum logic {
      IDLE,
      ISSUE
   } stateT;

   // FIFO storage and pointers
   logic [entW-1:0]     mem [0:cap-1];
   logic [FA-1:0]       wrPtr;
   logic [FA-1:0]       rdPtr;
   logic [entW-1:0]     headEnt;
   logic [insWidth-1:0] headIns;
   logic [RW-1:0]       headRpt;
   logic                push;
   logic                pop;

   // FSM state and issue context
   stateT               state;
   stateT               stateNxt;
   logic [insWidth-1:0] curIns;
   logic [insWidth-1:0] curInsNxt;
   logic [RW-1:0]       rem;
   logic [RW-1:0]       remNxt;
   logic                slot;
   logic                drainedNxt;
   logic [insWidth-1:0] instructionNxt;
   logic                haveEntry;

   assign hostReady = (count != fullCount);
   assign push      = hostValid && hostReady;
   assign headEnt   = mem[rdPtr];
   assign headIns   = headEnt[insWidth-1:0];
   assign headRpt   = headEnt[entW-1 -: RW];
   assign busy      = (state == ISSUE);
   // Pre-edge occupancy: a word pushed this cycle is not poppable until next.
   assign haveEntry = run && (count != '0);

   // FIFO payload write; contents need no reset since count gates reads
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wrPtr] <= {hostRpt, hostIns};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + FA'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + FA'(1);
         end
         if (push && !pop) begin
            count <= count + (FA + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (FA + 1)'(1);
         end
      end
   end

   // State register and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         curIns      <= NOP;
         rem         <= '0;
         instruction <= NOP;
         drained     <= 1'b0;
      end else begin
         state       <= stateNxt;
         curIns      <= curInsNxt;
         rem         <= remNxt;
         instruction <= instructionNxt;
         drained     <= drainedNxt;
      end
   end

   // Next-state: fetch in IDLE, count down repeats in ISSUE, chain entries
   always_comb begin
      stateNxt   = state;
      curInsNxt  = curIns;
      remNxt     = rem;
      pop        = 1'b0;
      slot       = 1'b0;
      drainedNxt = 1'b0;
      case (state)
         IDLE: begin
            if (haveEntry) begin
               pop       = 1'b1;
               curInsNxt = headIns;
               remNxt    = headRpt;
               stateNxt  = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               slot = 1'b1;
               if (rem != '0) begin
                  remNxt = rem - RW'(1);
               end else if (haveEntry) begin
                  // Back-to-back load: the next cycle is already a slot.
                  pop       = 1'b1;
                  curInsNxt = headIns;
                  remNxt    = headRpt;
               end else begin
                  stateNxt   = IDLE;
                  drainedNxt = 1'b1;
               end
            end
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
      instructionNxt = slot ? curIns : NOP;
   end

endmodule
